// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier arbiter.
// Operand/product widths, multiplier op codes and a width helper.
package mul_arb_pkg;

    localparam int unsigned MUL_OP_W = 3;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned PROD_W   = 64;

    typedef enum logic [MUL_OP_W-1:0] {
        MUL_OP_MULU = 3'b000,
        MUL_OP_MUL  = 3'b001,
        MUL_OP_MULH = 3'b010
    } mul_op_e;

    // Bits needed to index n entries; never less than one.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/mul_arb_tag_fifo.sv
// Tag FIFO: records the requester index of each op in flight in the multiplier.
// Synchronous push/pop; push and pop in the same cycle leave the count unchanged.
module mul_arb_tag_fifo
    import mul_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1
) (
    input  logic             mul_clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic [CntW-1:0]  count_d;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge mul_clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge mul_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/mul_arbiter.sv
// Shares one pipelined multiplier among NREQ requesters and routes products back in issue order.
// Define MUL_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned TAG_DEPTH = 2
) (
    input  logic                     mul_clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [MUL_OP_W*NREQ-1:0] req_op,
    input  logic [XLEN*NREQ-1:0]     req_x,
    input  logic [XLEN*NREQ-1:0]     req_y,
    output logic [NREQ-1:0]          resp_valid,
    input  logic [NREQ-1:0]          resp_ready,
    output logic [PROD_W-1:0]        resp_result,
    output logic                     m_req_valid,
    input  logic                     m_req_ready,
    output logic [MUL_OP_W-1:0]      m_op,
    output logic [XLEN-1:0]          m_x,
    output logic [XLEN-1:0]          m_y,
    input  logic                     m_resp_valid,
    output logic                     m_resp_ready,
    input  logic [PROD_W-1:0]        m_result
);
    localparam int unsigned TagW = clog2(NREQ);

    logic [TagW-1:0] arb_idx;
    logic [TagW-1:0] grant;
    logic [TagW-1:0] locked_idx_q;
    logic            lock_q;
    logic            accept;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [TagW-1:0] head;

`ifdef MUL_ARB_RR_EN
    logic [TagW-1:0] rr_ptr_q;
    logic [TagW-1:0] cand;

    // Walk backwards so the candidate closest to rr_ptr_q is assigned last and wins.
    always_comb begin
        arb_idx = '0;
        cand    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = TagW'((int'(rr_ptr_q) + k) % NREQ);
            if (req_valid[cand]) begin
                arb_idx = cand;
            end
        end
    end

    always_ff @(posedge mul_clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else if (accept) begin
            rr_ptr_q <= (grant == TagW'(NREQ - 1)) ? '0 : grant + TagW'(1);
        end
    end
`else
    always_comb begin
        arb_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                arb_idx = TagW'(k);
            end
        end
    end
`endif

    // A stalled handshake pins the grant until the multiplier takes it.
    assign grant = lock_q ? locked_idx_q : arb_idx;

    always_ff @(posedge mul_clk) begin
        if (reset) begin
            lock_q       <= 1'b0;
            locked_idx_q <= '0;
        end else if (accept) begin
            lock_q <= 1'b0;
        end else if (m_req_valid) begin
            lock_q       <= 1'b1;
            locked_idx_q <= grant;
        end
    end

    assign m_req_valid = !reset && (|req_valid) && !fifo_full;
    assign accept      = m_req_valid && m_req_ready;
    assign m_op        = req_op[MUL_OP_W*grant +: MUL_OP_W];
    assign m_x         = req_x[XLEN*grant +: XLEN];
    assign m_y         = req_y[XLEN*grant +: XLEN];

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i]  = accept && (grant == TagW'(i));
            resp_valid[i] = !reset && m_resp_valid && !fifo_empty && (head == TagW'(i));
        end
    end

    assign m_resp_ready = !reset && !fifo_empty && resp_ready[head];
    assign resp_result  = m_result;
    assign pop          = m_resp_valid && m_resp_ready;

    mul_arb_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (TagW)
    ) u_tag_fifo (
        .mul_clk   (mul_clk),
        .reset     (reset),
        .push      (accept),
        .push_data (grant),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifndef SYNTHESIS
    resp_without_tag_a: assert property (@(posedge mul_clk) disable iff (reset)
        !(m_resp_valid && fifo_empty))
        else $error("mul_arbiter: multiplier response with no op in flight");
`endif

endmodule
